// File: rtl/vga_pkg.sv
// Shared XGA (1024x768@60 Hz, 65 MHz pclk) timing constants for the VGA pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a. Also used by the draw stages and racket limit logic.
package vga_pkg;

    // Counter width; every timing sum must stay below 2**CNT_W.
    localparam int CNT_W = 11;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1344

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806

    // Asserted level of hsync_out/vsync_out.
    localparam logic SYNC_ACTIVE = 1'b1;

endpackage

// File: rtl/vga_timing.sv
// Source of the VGA pixel stream: h/v counters, sync, blanking and a once-per-frame tick.
// Latency: all outputs registered; flags describe the same pixel as the counts on the same cycle.
// Backpressure: none; en=0 freezes every output (frame_tick forced low that cycle).
//
// Ports:
//   pclk, rst          pixel clock, asynchronous active-high reset
//   en                 count enable
//   hcount_out/vcount_out  current pixel position
//   hsync_out/vsync_out    sync pulses at SYNC_ACTIVE level
//   hblnk_out/vblnk_out    blanking flags
//   frame_tick         one-cycle pulse at the first blank pixel of each frame
module vga_timing
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_pkg::H_FP,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BP        = vga_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_pkg::V_FP,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BP        = vga_pkg::V_BP,
    parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE
)
(
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic             frame_tick
);

    localparam int LT_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int LT_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width copies of the decode points; sync end values are exclusive.
    localparam logic [CNT_W-1:0] C_H_LAST     = CNT_W'(LT_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST     = CNT_W'(LT_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_TICK     = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] C_HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] C_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] C_VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] C_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    // Timing totals (and thus every sync end point) must fit the counters.
    if (LT_H_TOTAL >= (1 << CNT_W) || LT_V_TOTAL >= (1 << CNT_W) || V_ACTIVE < 1) begin : g_width_check
        $error("vga_timing: timing parameters do not fit %0d-bit counters", CNT_W);
    end

    logic [CNT_W-1:0] r_hcount;
    logic [CNT_W-1:0] r_vcount;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblnk;
    logic             r_vblnk;
    logic             r_tick;

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic [CNT_W-1:0] w_hcount_nxt;
    logic [CNT_W-1:0] w_vcount_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_hblnk_nxt;
    logic             w_vblnk_nxt;
    logic             w_tick_nxt;

    // Decodes are taken from the next counter values so the registered flags
    // line up with the registered counts without any extra pipeline stage.
    always_comb begin
        w_h_wrap     = (r_hcount == C_H_LAST);
        w_v_wrap     = (r_vcount == C_V_LAST);
        w_hcount_nxt = w_h_wrap ? '0 : r_hcount + CNT_W'(1);
        w_vcount_nxt = r_vcount;
        if (w_h_wrap) begin
            w_vcount_nxt = w_v_wrap ? '0 : r_vcount + CNT_W'(1);
        end
        w_hsync_nxt  = (w_hcount_nxt >= C_HS_START) && (w_hcount_nxt < C_HS_END);
        w_vsync_nxt  = (w_vcount_nxt >= C_VS_START) && (w_vcount_nxt < C_VS_END);
        w_hblnk_nxt  = (w_hcount_nxt >= C_H_ACT);
        w_vblnk_nxt  = (w_vcount_nxt >= C_V_ACT);
        w_tick_nxt   = (w_hcount_nxt == C_H_ACT) && (w_vcount_nxt == C_V_TICK);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= ~SYNC_ACTIVE;
            r_vsync  <= ~SYNC_ACTIVE;
            r_hblnk  <= 1'b0;
            r_vblnk  <= 1'b0;
            r_tick   <= 1'b0;
        end else if (en) begin
            r_hcount <= w_hcount_nxt;
            r_vcount <= w_vcount_nxt;
            r_hsync  <= w_hsync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync  <= w_vsync_nxt ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_hblnk  <= w_hblnk_nxt;
            r_vblnk  <= w_vblnk_nxt;
            r_tick   <= w_tick_nxt;
        end else begin
            // Frozen: positions and flags hold, but the tick must not repeat.
            r_tick   <= 1'b0;
        end
    end

    assign hcount_out = r_hcount;
    assign vcount_out = r_vcount;
    assign hsync_out  = r_hsync;
    assign vsync_out  = r_vsync;
    assign hblnk_out  = r_hblnk;
    assign vblnk_out  = r_vblnk;
    assign frame_tick = r_tick;

endmodule
